// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit
//   Iterative RV32M multiply/divide unit for the EX stage. A shift-add
//   multiplier (one multiplier bit per cycle, LSB first) and a restoring
//   divider (one quotient bit per cycle, MSB first) share one pair of
//   XLEN-bit working registers. Operands are reduced to magnitudes on
//   acceptance and the result sign is applied once at the end.
//
// Ports
//   CLK     in   1     rising-edge clock
//   RESET   in   1     synchronous active-high reset
//   START   in   1     request, accepted when BUSY=0 and KILL=0
//   OP      in   3     funct3 (MUL MULH MULHSU MULHU DIV DIVU REM REMU)
//   DATA1   in   XLEN  rs1 (multiplicand / dividend)
//   DATA2   in   XLEN  rs2 (multiplier / divisor)
//   KILL    in   1     flush: abort any in-flight op, no VALID
//   BUSY    out  1     high while an op is in flight
//   VALID   out  1     one-cycle pulse when RESULT is updated
//   RESULT  out  XLEN  last completed result, held until the next VALID
module muldiv_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            KILL,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MINV = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic [XLEN-1:0]  mcand;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]  hi;       // product high half / partial remainder
  logic [XLEN-1:0]  lo;       // multiplier-then-product low half / quotient
  logic             neg_r;    // result must be negated in FIX
  logic             special_r;// lo already holds the final result
  logic             hold_r;   // fast path waits one extra cycle in FIX

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Acceptance decode: operand signs, magnitudes and special cases
  logic            sgn1, sgn2, a_neg, b_neg, res_neg, div0, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    // MULHU, DIVU, REMU treat rs1 as unsigned; only MUL/MULH/DIV/REM sign rs2
    sgn1     = !(OP == 3'b011 || OP == 3'b101 || OP == 3'b111);
    sgn2     = (OP == 3'b000 || OP == 3'b001 || OP == 3'b100 || OP == 3'b110);
    a_neg    = sgn1 && DATA1[XLEN-1];
    b_neg    = sgn2 && DATA2[XLEN-1];
    a_mag    = neg_w(DATA1, a_neg);
    b_mag    = neg_w(DATA2, b_neg);
    // Remainder takes the dividend sign; everything else takes s1^s2
    res_neg  = (OP[2] && OP[1]) ? a_neg : (a_neg ^ b_neg);
    div0     = OP[2] && (DATA2 == '0);
    ovf      = OP[2] && !OP[0] && (DATA1 == MINV) && (DATA2 == '1);
    special  = div0 || ovf;
    spec_val = '0;
    if (div0)
      spec_val = OP[1] ? DATA1 : '1;
    else if (ovf)
      spec_val = OP[1] ? '0 : DATA1;
  end

  // One iteration of shift-add multiply or restoring divide
  logic [XLEN:0]   mul_sum, div_trial;
  logic [XLEN-1:0] addend, step_hi, step_lo;

  always_comb begin
    addend    = lo[0] ? mcand : '0;
    mul_sum   = {1'b0, hi} + {1'b0, addend};
    div_trial = {hi, lo[XLEN-1]} - {1'b0, mcand};
    if (op_r[2]) begin
      // A clear borrow bit means the divisor fits: keep the difference
      if (!div_trial[XLEN]) begin
        step_hi = div_trial[XLEN-1:0];
        step_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = {hi[XLEN-2:0], lo[XLEN-1]};
        step_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // Final sign fix-up and half / quotient / remainder selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod_fix = neg_2w({hi, lo}, neg_r);
    if (special_r)
      fix_res = lo;
    else if (op_r[2])
      fix_res = op_r[1] ? neg_w(hi, neg_r) : neg_w(lo, neg_r);
    else if (op_r[1:0] == 2'b00)
      fix_res = prod_fix[XLEN-1:0];
    else
      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= '0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      neg_r     <= 1'b0;
      special_r <= 1'b0;
      hold_r    <= 1'b0;
      BUSY      <= 1'b0;
      VALID     <= 1'b0;
      RESULT    <= '0;
    end else if (KILL) begin
      state  <= IDLE;
      hold_r <= 1'b0;
      BUSY   <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op_r  <= OP;
            neg_r <= res_neg;
            cnt   <= '0;
            hi    <= '0;
            BUSY  <= 1'b1;
            if (special) begin
              lo        <= spec_val;
              mcand     <= '0;
              special_r <= 1'b1;
              hold_r    <= 1'b1;
              state     <= FIX;
            end else begin
              // Divide iterates over the dividend, multiply over the multiplier
              lo        <= OP[2] ? a_mag : b_mag;
              mcand     <= OP[2] ? b_mag : a_mag;
              special_r <= 1'b0;
              hold_r    <= 1'b0;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST)
            state <= FIX;
        end
        FIX: begin
          if (hold_r) begin
            hold_r <= 1'b0;
          end else begin
            RESULT <= fix_res;
            VALID  <= 1'b1;
            BUSY   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
module tb_muldiv_seq_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [2:0]  OP = '0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        KILL = 1'b0;
  logic        BUSY, VALID;
  logic [31:0] RESULT;

  int tests = 0;
  int failed = 0;

  muldiv_seq_unit #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .DATA1(DATA1),
    .DATA2(DATA2), .KILL(KILL), .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: RV32M results from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = '0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >> 32; end
      3'd2: begin p = sa * ub; p = p >> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
    return p[31:0];
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 2;
    return 33;
  endfunction

  // Drive a request now; returns just after the accepting edge
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    START = 1'b1; OP = op; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0; OP = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom;
  endtask

  // Called just after the accepting edge; leaves time just after the VALID edge
  task automatic wait_result(input string nm, input logic [31:0] exp, input int exp_lat);
    int n;
    bit got, dropped;
    n = 0; got = 0; dropped = 0;
    chk({nm, "_busy_on_accept"}, 32'(BUSY), 32'd1);
    while (!got && n < 60) begin
      @(posedge CLK); #1;
      n++;
      if (VALID) got = 1;
      else if (!BUSY) dropped = 1;
    end
    chk({nm, "_valid_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_busy_held"}, 32'(dropped), 32'd0);
    chk({nm, "_result"}, RESULT, exp);
    chk({nm, "_busy_in_valid"}, 32'(BUSY), 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge CLK);
    launch(op, a, b);
    wait_result(nm, exp, lat);
  endtask

  task automatic watch_no_valid(input string nm, input int cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (VALID) seen = 1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] kept, ra, rb;
    logic [2:0]  rop;
    int          sel;

    tbl[0]  = '{"mul_7_m3",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    tbl[1]  = '{"mulh_min_min",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    tbl[2]  = '{"mulhsu_m1_max",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    tbl[3]  = '{"mulhu_max_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    tbl[4]  = '{"div_m7_2",        3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    tbl[5]  = '{"rem_m7_2",        3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    tbl[6]  = '{"divu_100_7",      3'd5, 32'd100,      32'd7,        32'd14,       33};
    tbl[7]  = '{"remu_100_7",      3'd7, 32'd100,      32'd7,        32'd2,        33};
    tbl[8]  = '{"div_by_zero",     3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    tbl[9]  = '{"remu_by_zero",    3'd7, 32'h1234,     32'd0,        32'h1234,     2};
    tbl[10] = '{"div_overflow",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    tbl[11] = '{"rem_overflow",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        2};
    tbl[12] = '{"divu_by_zero",    3'd5, 32'd77,       32'd0,        32'hFFFFFFFF, 2};
    tbl[13] = '{"rem_by_zero",     3'd6, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 2};

    // Reset state
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_valid", 32'(VALID), 32'd0);
    chk("reset_result", RESULT, 32'd0);

    // Directed vectors
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // START re-asserted while busy is ignored
    @(negedge CLK);
    launch(3'd0, 32'd1000, 32'd3);
    repeat (4) @(posedge CLK);
    #1 START = 1'b1; OP = 3'd5; DATA1 = 32'd9; DATA2 = 32'd2;
    repeat (3) @(posedge CLK);
    #1 START = 1'b0;
    begin
      int n;
      bit got;
      n = 7; got = 0;
      while (!got && n < 60) begin
        @(posedge CLK); #1;
        n++;
        if (VALID) got = 1;
      end
      chk("busy_start_latency", 32'(n), 32'd33);
      chk("busy_start_result", RESULT, 32'd3000);
    end
    @(posedge CLK); #1;
    chk("busy_start_not_queued", 32'(BUSY), 32'd0);

    // Back-to-back: START in the VALID cycle is accepted
    @(negedge CLK);
    launch(3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_result("b2b_first", 32'h3FFFFFFF, 33);
    launch(3'd6, 32'hFFFFFF9C, 32'd7);
    wait_result("b2b_second", 32'hFFFFFFFE, 33);

    // START and KILL on the same edge: nothing accepted
    @(negedge CLK);
    START = 1'b1; KILL = 1'b1; OP = 3'd0; DATA1 = 32'd5; DATA2 = 32'd5;
    @(posedge CLK); #1;
    START = 1'b0; KILL = 1'b0;
    chk("start_kill_busy", 32'(BUSY), 32'd0);
    watch_no_valid("start_kill_no_valid", 5);

    // KILL at iteration 10
    kept = RESULT;
    @(negedge CLK);
    launch(3'd0, 32'd123, 32'd456);
    repeat (9) @(posedge CLK);
    #1 KILL = 1'b1;
    @(posedge CLK); #1;
    KILL = 1'b0;
    chk("kill_busy", 32'(BUSY), 32'd0);
    chk("kill_valid", 32'(VALID), 32'd0);
    chk("kill_result_kept", RESULT, kept);
    watch_no_valid("kill_no_valid", 40);

    // RESET at iteration 5 of a new op
    @(negedge CLK);
    launch(3'd5, 32'd1000, 32'd9);
    repeat (4) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("rst_mid_busy", 32'(BUSY), 32'd0);
    chk("rst_mid_valid", 32'(VALID), 32'd0);
    chk("rst_mid_result", RESULT, 32'd0);
    watch_no_valid("rst_mid_no_valid", 40);
    run_op("after_reset", 3'd5, 32'd1000, 32'd9, 32'd111, 33);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) rb = -32'($urandom_range(1, 15));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), model_lat(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
